cluster_unpacker384: RTL and testbench



---
 rtl/cluster_unpacker384.sv | 158 +++++++++++++++
 tb/tb_cluster_unpacker384.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cluster_unpacker384.sv
// cluster_unpacker384: rebuilds the per-pad valid bitmap and count vector of one
// frame from a serial stream of encoded clusters (adr, cnt, vpf).
// Optional feature macro: CLUSTER_WIDTH_EXPAND_EN. When it is defined, an accepted
// cluster also marks pads adr+1..adr+cnt as valid, reproducing the hit width.

// Per-pad accumulator plus the registered output copy of that pad.
module cluster_unpacker384_pad #(
  parameter int MXCNTB = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              set,
  input  logic              wr,
  input  logic              close,
  input  logic [MXCNTB-1:0] cnt,
  output logic              vpf_out,
  output logic [MXCNTB-1:0] cnt_out
);
  logic              acc_vpf;
  logic [MXCNTB-1:0] acc_cnt;
  logic              vpf_nxt;
  logic [MXCNTB-1:0] cnt_nxt;

  // Merge the current word before deciding whether to publish or keep accumulating.
  always_comb begin
    vpf_nxt = acc_vpf | set;
    cnt_nxt = wr ? cnt : acc_cnt;
  end

  // On frame close publish the merged value and start the next frame from zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_vpf <= 1'b0;
      acc_cnt <= '0;
      vpf_out <= 1'b0;
      cnt_out <= '0;
    end else if (close) begin
      vpf_out <= vpf_nxt;
      cnt_out <= cnt_nxt;
      acc_vpf <= 1'b0;
      acc_cnt <= '0;
    end else begin
      acc_vpf <= vpf_nxt;
      acc_cnt <= cnt_nxt;
    end
  end
endmodule

module cluster_unpacker384 #(
  parameter int MXKEYS     = 384,
  parameter int MXKEYBITS  = 9,
  parameter int MXCNTB     = 3,
  parameter int MXCLUSTERS = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clu_valid,
  input  logic                     clu_vpf,
  input  logic [MXKEYBITS-1:0]     clu_adr,
  input  logic [MXCNTB-1:0]        clu_cnt,
  input  logic                     clu_last,
  input  logic [2:0]               pass_in,
  output logic                     frame_valid,
  output logic [MXKEYS-1:0]        vpfs_out,
  output logic [MXKEYS*MXCNTB-1:0] cnts_out,
  output logic [2:0]               pass_out,
  output logic                     overflow,
  output logic [7:0]               err_cnt
);
  localparam int CW = $clog2(MXCLUSTERS + 1);
  localparam logic [MXKEYBITS:0] KEYS_W = (MXKEYBITS+1)'(MXKEYS);
  localparam logic [CW-1:0]      MAXC   = CW'(MXCLUSTERS);

  typedef enum logic [1:0] {IDLE, ACCUM, DROP} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] clu_count, cnt_inc;
  logic [2:0]    pass_lat;
  logic          ovf_flag;
  logic          in_range, full, close, accept, bad, ovf_drop;

  assign in_range = {1'b0, clu_adr} < KEYS_W;
  assign full     = (state == DROP);
  assign close    = clu_valid & clu_last;
  assign accept   = clu_valid & clu_vpf & in_range & ~full;
  assign bad      = clu_valid & clu_vpf & ~in_range & ~full;
  assign ovf_drop = clu_valid & full;
  assign cnt_inc  = clu_count + CW'(1);

`ifdef CLUSTER_WIDTH_EXPAND_EN
  logic [MXKEYBITS:0] span_end;
  assign span_end = {1'b0, clu_adr} + (MXKEYBITS+1)'(clu_cnt);
`endif

  // Next-state: the last word always closes the frame; filling the cluster budget
  // without closing moves to DROP.
  always_comb begin
    state_nxt = state;
    if (close)                           state_nxt = IDLE;
    else if (accept && cnt_inc == MAXC)  state_nxt = DROP;
    else if (clu_valid && state == IDLE) state_nxt = ACCUM;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Frame bookkeeping: cluster count, overflow, sideband tag, error counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      frame_valid <= 1'b0;
      pass_out    <= '0;
      pass_lat    <= '0;
      overflow    <= 1'b0;
      ovf_flag    <= 1'b0;
      clu_count   <= '0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= close;
      if (clu_valid && state == IDLE) pass_lat <= pass_in;
      if (close) begin
        // A single-word frame has its tag on the bus right now, not in pass_lat.
        pass_out  <= (state == IDLE) ? pass_in : pass_lat;
        overflow  <= ovf_flag | ovf_drop;
        ovf_flag  <= 1'b0;
        clu_count <= '0;
      end else begin
        if (ovf_drop) ovf_flag  <= 1'b1;
        if (accept)   clu_count <= cnt_inc;
      end
      if ((bad || ovf_drop) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  for (genvar i = 0; i < MXKEYS; i++) begin : g_pad
    logic wr, set;
    assign wr = accept && (clu_adr == MXKEYBITS'(i));
`ifdef CLUSTER_WIDTH_EXPAND_EN
    // Pads past MXKEYS-1 do not exist, so the span is clipped for free.
    assign set = wr || (accept && ({1'b0, clu_adr} < (MXKEYBITS+1)'(i))
                               && ((MXKEYBITS+1)'(i) <= span_end));
`else
    assign set = wr;
`endif
    cluster_unpacker384_pad #(.MXCNTB(MXCNTB)) u_pad (
      .clock   (clock),
      .reset_n (reset_n),
      .set     (set),
      .wr      (wr),
      .close   (close),
      .cnt     (clu_cnt),
      .vpf_out (vpfs_out[i]),
      .cnt_out (cnts_out[i*MXCNTB +: MXCNTB])
    );
  end
endmodule

// File: tb/tb_cluster_unpacker384.sv
// Bench for cluster_unpacker384: a frame-level model predicts every output on
// every cycle, plus literal expectations for the directed scenarios.
module tb_cluster_unpacker384;
  localparam int K = 384;
  localparam int C = K * 3;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           clu_valid = 1'b0, clu_vpf = 1'b0, clu_last = 1'b0;
  logic [8:0]     clu_adr = '0;
  logic [2:0]     clu_cnt = '0, pass_in = '0;
  logic           frame_valid, overflow;
  logic [K-1:0]   vpfs_out;
  logic [C-1:0]   cnts_out;
  logic [2:0]     pass_out;
  logic [7:0]     err_cnt;

  cluster_unpacker384 dut (
    .clock(clock), .reset_n(reset_n), .clu_valid(clu_valid), .clu_vpf(clu_vpf),
    .clu_adr(clu_adr), .clu_cnt(clu_cnt), .clu_last(clu_last), .pass_in(pass_in),
    .frame_valid(frame_valid), .vpfs_out(vpfs_out), .cnts_out(cnts_out),
    .pass_out(pass_out), .overflow(overflow), .err_cnt(err_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  bit run = 0;

  // Model state: the frame being collected and the outputs it must produce.
  logic [K-1:0] m_vpf;
  logic [C-1:0] m_cnt;
  int           m_count, m_err;
  bit           m_ovf, m_first;
  logic [2:0]   m_pass;
  logic         exp_fv, exp_ovf;
  logic [K-1:0] exp_vpfs;
  logic [C-1:0] exp_cnts;
  logic [2:0]   exp_pass;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [C-1:0] act, input logic [C-1:0] exp);
    int idx;
    checks++;
    if (act !== exp) begin
      failures++;
      idx = -1;
      for (int i = C - 1; i >= 0; i--) if (act[i] !== exp[i]) idx = i;
      $display("FAIL %s first differing bit %0d act=%b exp=%b at %0t",
               nm, idx, act[idx], exp[idx], $time);
    end
  endtask

  // Apply the word on the bus (as sampled at this edge) to the model.
  task automatic model_step();
    if (!reset_n) begin
      m_vpf = '0; m_cnt = '0; m_count = 0; m_ovf = 0; m_first = 1; m_err = 0;
      exp_fv = 0; exp_vpfs = '0; exp_cnts = '0; exp_pass = '0; exp_ovf = 0;
    end else begin
      exp_fv = 0;
      if (clu_valid) begin
        if (m_first) begin m_pass = pass_in; m_first = 0; end
        if (m_count == 8) begin m_err++; m_ovf = 1; end
        else if (clu_vpf) begin
          if (int'(clu_adr) >= K) m_err++;
          else begin
            m_vpf[clu_adr] = 1'b1;
            m_cnt[int'(clu_adr)*3 +: 3] = clu_cnt;
`ifdef CLUSTER_WIDTH_EXPAND_EN
            for (int k = 1; k <= int'(clu_cnt); k++)
              if (int'(clu_adr) + k < K) m_vpf[int'(clu_adr) + k] = 1'b1;
`endif
            m_count++;
          end
        end
        if (m_err > 255) m_err = 255;
        if (clu_last) begin
          exp_fv = 1; exp_vpfs = m_vpf; exp_cnts = m_cnt; exp_pass = m_pass; exp_ovf = m_ovf;
          m_vpf = '0; m_cnt = '0; m_count = 0; m_ovf = 0; m_first = 1;
        end
      end
    end
  endtask

  // One clock with the given word (v=0 for an idle cycle).
  task automatic cyc(input logic v, input logic vpf, input int adr, input int cnt,
                     input logic last, input logic [2:0] pass);
    clu_valid = v; clu_vpf = vpf; clu_adr = 9'(adr); clu_cnt = 3'(cnt);
    clu_last = last; pass_in = pass;
    @(posedge clock);
    model_step();
    run = 1;
    #1;
    clu_valid = 0; clu_last = 0; clu_vpf = 0;
  endtask

  task automatic rst_cyc();
    reset_n = 0;
    cyc(0, 0, 0, 0, 0, 0);
    reset_n = 1;
  endtask

  // Every cycle: all outputs against the model.
  always @(negedge clock) begin
    if (run) begin
      chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
      chkw("vpfs_out", C'(vpfs_out), C'(exp_vpfs));
      chkw("cnts_out", cnts_out, exp_cnts);
      chk("pass_out", 32'(pass_out), 32'(exp_pass));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("err_cnt", 32'(err_cnt), m_err);
    end
  end

  logic [K-1:0] one;
  logic [K-1:0] lit;

  initial begin
    one = 1;
    rst_cyc(); rst_cyc();
    chk("reset_fv", 32'(frame_valid), 0);
    chk("reset_err", 32'(err_cnt), 0);
    chkw("reset_vpfs", C'(vpfs_out), '0);

    // Single cluster, single-word frame.
    cyc(1, 1, 5, 3, 1, 3'b101);
`ifdef CLUSTER_WIDTH_EXPAND_EN
    lit = one << 5 | one << 6 | one << 7 | one << 8;
`else
    lit = one << 5;
`endif
    chk("t1_fv", 32'(frame_valid), 1);
    chkw("t1_vpfs", C'(vpfs_out), C'(lit));
    chk("t1_cnt5", 32'(cnts_out[17:15]), 3);
    chk("t1_pass", 32'(pass_out), 5);
    chk("t1_ovf", 32'(overflow), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t1_fv_drop", 32'(frame_valid), 0);

    // Empty frame filler.
    cyc(1, 0, 511, 0, 1, 3'b010);
    chk("t2_fv", 32'(frame_valid), 1);
    chkw("t2_vpfs", C'(vpfs_out), '0);
    chkw("t2_cnts", cnts_out, '0);
    chk("t2_err", 32'(err_cnt), 0);
    chk("t2_pass", 32'(pass_out), 2);

    // Nine clusters: the ninth overflows and is dropped.
    for (int i = 0; i < 9; i++) cyc(1, 1, i, 0, i == 8, 3'b011);
    chkw("t3_vpfs", C'(vpfs_out), C'(K'(384'hFF)));
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_err", 32'(err_cnt), 1);
    cyc(0, 0, 0, 0, 0, 0);

    // Bad address alongside pad 383; tag comes from the first word only.
    cyc(1, 1, 383, 6, 0, 3'b001);
    cyc(1, 1, 400, 2, 1, 3'b110);
    chkw("t4_vpfs", C'(vpfs_out), C'(one << 383));
    chk("t4_cnt383", 32'(cnts_out[1151:1149]), 6);
    chk("t4_err", 32'(err_cnt), 2);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_pass", 32'(pass_out), 1);

    // Duplicate address: later count wins.
    cyc(1, 1, 7, 2, 0, 3'b100);
    cyc(1, 1, 7, 5, 1, 3'b000);
    chk("dup_cnt7", 32'(cnts_out[23:21]), 5);

    // Back-to-back frames.
    cyc(1, 1, 10, 1, 1, 3'b001);
    chk("b2b_fv1", 32'(frame_valid), 1);
    chkw("b2b_vpfs1", C'(vpfs_out), C'(one << 10));
    cyc(1, 1, 20, 2, 1, 3'b010);
    chk("b2b_fv2", 32'(frame_valid), 1);
    chkw("b2b_vpfs2", C'(vpfs_out), C'(one << 20));
    chk("b2b_pass2", 32'(pass_out), 2);
    cyc(0, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0);
    chkw("hold_vpfs", C'(vpfs_out), C'(one << 20));

    // Reset mid-frame discards the partial frame.
    cyc(1, 1, 1, 0, 0, 3'b111);
    cyc(1, 1, 2, 0, 0, 3'b111);
    rst_cyc();
    chk("rst_fv", 32'(frame_valid), 0);
    cyc(1, 1, 3, 0, 1, 3'b011);
    chkw("rst_vpfs", C'(vpfs_out), C'(one << 3));
    chk("rst_pass", 32'(pass_out), 3);

    // Cluster near the top pad (span clipped when width expansion is on).
    cyc(1, 1, 382, 4, 1, 3'b000);
`ifdef CLUSTER_WIDTH_EXPAND_EN
    lit = one << 382 | one << 383;
`else
    lit = one << 382;
`endif
    chkw("top_vpfs", C'(vpfs_out), C'(lit));
    chk("top_cnt382", 32'(cnts_out[1148:1146]), 4);

    // err_cnt saturation.
    for (int i = 0; i < 260; i++) cyc(1, 1, 450, 0, i == 259, 3'b000);
    chk("sat_err", 32'(err_cnt), 255);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
